ysyx_25020047_wb_commit_ctrl: RTL and testbench
===============================================

// Module: ysyx_25020047_wb_commit_ctrl
// PURPOSE
//   Sequences writeback and commit for the NPC core, between EXU (one-hot inst_type + ALU result)
//   and the GPR file / PC register. Non-loads commit one cycle after acceptance. Loads (lw, lbu)
//   first issue a memory read and wait for the response, then commit. Emits a 1-cycle commit pulse
//   for difftest, and flags unknown instructions and memory timeouts.
// PARAMETERS
//   MEM_TIMEOUT  255  max cycles spent in MEM_REQ+MEM_WAIT before forced commit with err
// PORTS
//   clk           in   1   system clock, rising edge
//   rst_n         in   1   asynchronous, active-low reset
//   in_valid      in   1   EXU presents an executed instruction
//   in_ready      out  1   controller accepts; = (state==IDLE)
//   in_inst_type  in   64  one-hot inst class (bit0 addi .. bit31 bgeu, core encoding)
//   in_rd         in   5   destination register index
//   in_result     in   32  ALU result / jump target / load address
//   in_snpc       in   32  pc+4
//   mem_req_valid out  1   load read request
//   mem_req_ready in   1   memory accepts request
//   mem_req_addr  out  32  {result[31:2],2'b00}
//   mem_rvalid    in   1   read data valid
//   mem_rdata     in   32  read word
//   gpr_wen       out  1   GPR write strobe (1 cycle)
//   gpr_waddr     out  5   GPR write index
//   gpr_wdata     out  32  GPR write data
//   pc_wen        out  1   PC update strobe (1 cycle, every commit)
//   pc_dnpc       out  32  next PC
//   commit_valid  out  1   1-cycle pulse per retired instruction
//   err           out  1   1-cycle pulse with commit: unknown inst_type or mem timeout
// BEHAVIOUR
//   Reset: state=IDLE; all outputs 0 except in_ready (=1 once IDLE); latched fields cleared.
//   Reset mid-operation aborts immediately; pending request/response discarded.
//   States: IDLE -> (accept, non-load) COMMIT; IDLE -> (accept, load) MEM_REQ;
//     MEM_REQ -> (mem_req_ready) MEM_WAIT; MEM_WAIT -> (mem_rvalid) COMMIT; COMMIT -> IDLE.
//   Accept = in_valid & in_ready; all in_* fields latched on accept; inputs ignored otherwise.
//   mem_req_valid high throughout MEM_REQ, addr stable until handshake.
//   mem_rvalid sampled only in MEM_WAIT; rvalid in other states ignored (no buffering).
//   Latency: non-load commit pulse in cycle after accept; load = 1 + req wait + rsp wait + 1.
//   Decode at commit (latched inst_type, exactly one bit set):
//     ALU class bits 0,3,4,9,11,12,13,16-20,22-27: wdata=result, dnpc=snpc, write.
//     Link bits 1 (jalr),10 (jal): wdata=snpc, dnpc=result, write.
//     Branch bits 14,15,28-31: dnpc=result, no write.
//     Load bit5 lw: wdata=mem_rdata; bit6 lbu: byte lane result[1:0], zero-extended.
//     Zero, multi-hot or unlisted bit: no write, dnpc=snpc, err=1; treated as non-load.
//   gpr_wen suppressed when rd==0 (x0); pc_wen and commit_valid still pulse.
//   Timeout: counter clears on entering MEM_REQ, +1 per cycle in MEM_REQ/MEM_WAIT; at
//     MEM_TIMEOUT -> COMMIT with no GPR write, dnpc=snpc, err=1; late rvalid ignored.
//   Outputs registered; gpr_*/pc_*/commit/err deasserted to 0 outside COMMIT.
// TESTING
//   addi rd=5 result=0x10: accept cyc0 -> cyc1 gpr_wen=1 waddr=5 wdata=0x10, dnpc=snpc, commit=1.
//   jal rd=1 result=0x80000100 snpc=0x80000008 -> wdata=0x80000008, pc_dnpc=0x80000100.
//   lbu result=0x80001003, req_ready after 2 cyc, rdata=0xAABBCCDD 3 cyc later -> wdata=0xAA.
//   bne result=0x80000040 rd=7 -> gpr_wen=0, pc_dnpc=0x80000040; addi rd=0 -> gpr_wen=0, commit=1.
//   lw, mem_rvalid never -> at MEM_TIMEOUT err=1, gpr_wen=0, dnpc=snpc; in_ready=1 next cycle.
//   rst_n low in MEM_WAIT then rvalid after release -> IDLE, no commit, no write.

Source files
------------

// File: rtl/ysyx_25020047_wb_commit_ctrl.sv
// Writeback/commit sequencer between EXU and the GPR file / PC register.
// Non-loads retire the cycle after acceptance; loads go through a memory read first.
module ysyx_25020047_wb_commit_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_inst_type,
   input  logic [4:0]  in_rd,
   input  logic [31:0] in_result,
   input  logic [31:0] in_snpc,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        gpr_wen,
   output logic [4:0]  gpr_waddr,
   output logic [31:0] gpr_wdata,
   output logic        pc_wen,
   output logic [31:0] pc_dnpc,
   output logic        commit_valid,
   output logic        err
);

   typedef enum logic [1:0] {S_IDLE, S_MEM_REQ, S_MEM_WAIT, S_COMMIT} state_t;

   localparam logic [63:0] ALU_MASK  = 64'h0000_0000_0FDF_3A19;
   localparam logic [63:0] LINK_MASK = 64'h0000_0000_0000_0402;
   localparam logic [63:0] BR_MASK   = 64'h0000_0000_F000_C000;
   localparam int unsigned CW        = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CW-1:0] LIMIT   = CW'(MEM_TIMEOUT - 1);

   state_t        r_state;
   logic [63:0]   r_type;
   logic [4:0]    r_rd;
   logic [31:0]   r_result;
   logic [31:0]   r_snpc;
   logic [CW-1:0] r_cnt;

   logic [63:0] w_type;
   logic [4:0]  w_rd;
   logic [31:0] w_result;
   logic [31:0] w_snpc;
   logic        w_onehot, w_alu, w_link, w_br, w_lw, w_lbu, w_in_load;
   logic [7:0]  w_lane;
   logic [31:0] w_wdata;
   logic [31:0] w_dnpc;
   logic        w_wr, w_err;
   logic        w_accept, w_in_mem, w_go_timeout, w_go_commit;

   assign in_ready = (r_state == S_IDLE);

   // Decode reads the live inputs on the accept cycle and the latched copy afterwards,
   // so a non-load can be committed straight from the accept edge.
   always_comb begin
      w_type   = in_ready ? in_inst_type : r_type;
      w_rd     = in_ready ? in_rd        : r_rd;
      w_result = in_ready ? in_result    : r_result;
      w_snpc   = in_ready ? in_snpc      : r_snpc;
      w_onehot = (w_type != '0) && ((w_type & (w_type - 64'd1)) == '0);
      w_alu    = w_onehot && ((w_type & ALU_MASK) != '0);
      w_link   = w_onehot && ((w_type & LINK_MASK) != '0);
      w_br     = w_onehot && ((w_type & BR_MASK) != '0);
      w_lw     = w_onehot && w_type[5];
      w_lbu    = w_onehot && w_type[6];
      w_in_load = w_lw || w_lbu;
      unique case (w_result[1:0])
         2'd0:    w_lane = mem_rdata[7:0];
         2'd1:    w_lane = mem_rdata[15:8];
         2'd2:    w_lane = mem_rdata[23:16];
         default: w_lane = mem_rdata[31:24];
      endcase
      w_wdata = '0;
      if (w_alu)       w_wdata = w_result;
      else if (w_link) w_wdata = w_snpc;
      else if (w_lw)   w_wdata = mem_rdata;
      else if (w_lbu)  w_wdata = {24'd0, w_lane};
      w_dnpc = (w_link || w_br) ? w_result : w_snpc;
      w_wr   = (w_alu || w_link || w_in_load) && (w_rd != '0);
      w_err  = !(w_alu || w_link || w_br || w_in_load);

      w_accept     = in_ready && in_valid;
      w_in_mem     = (r_state == S_MEM_REQ) || (r_state == S_MEM_WAIT);
      w_go_timeout = w_in_mem && (r_cnt == LIMIT);
      w_go_commit  = (w_accept && !w_in_load) ||
                     ((r_state == S_MEM_WAIT) && mem_rvalid && !w_go_timeout);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_type        <= '0;
         r_rd          <= '0;
         r_result      <= '0;
         r_snpc        <= '0;
         r_cnt         <= '0;
         mem_req_valid <= 1'b0;
         mem_req_addr  <= '0;
         gpr_wen       <= 1'b0;
         gpr_waddr     <= '0;
         gpr_wdata     <= '0;
         pc_wen        <= 1'b0;
         pc_dnpc       <= '0;
         commit_valid  <= 1'b0;
         err           <= 1'b0;
      end else begin
         gpr_wen      <= 1'b0;
         gpr_waddr    <= '0;
         gpr_wdata    <= '0;
         pc_wen       <= 1'b0;
         pc_dnpc      <= '0;
         commit_valid <= 1'b0;
         err          <= 1'b0;

         unique case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_type   <= in_inst_type;
                  r_rd     <= in_rd;
                  r_result <= in_result;
                  r_snpc   <= in_snpc;
                  if (w_in_load) begin
                     r_state       <= S_MEM_REQ;
                     r_cnt         <= '0;
                     mem_req_valid <= 1'b1;
                     mem_req_addr  <= {in_result[31:2], 2'b00};
                  end else begin
                     r_state <= S_COMMIT;
                  end
               end
            end
            S_MEM_REQ: begin
               r_cnt <= r_cnt + 1'b1;
               if (w_go_timeout) begin
                  r_state       <= S_COMMIT;
                  mem_req_valid <= 1'b0;
               end else if (mem_req_ready) begin
                  r_state       <= S_MEM_WAIT;
                  mem_req_valid <= 1'b0;
               end
            end
            S_MEM_WAIT: begin
               r_cnt <= r_cnt + 1'b1;
               if (w_go_timeout || mem_rvalid) r_state <= S_COMMIT;
            end
            S_COMMIT: r_state <= S_IDLE;
         endcase

         if (w_go_commit) begin
            gpr_wen      <= w_wr;
            gpr_waddr    <= w_rd;
            gpr_wdata    <= w_wdata;
            pc_wen       <= 1'b1;
            pc_dnpc      <= w_dnpc;
            commit_valid <= 1'b1;
            err          <= w_err;
         end else if (w_go_timeout) begin
            pc_wen       <= 1'b1;
            pc_dnpc      <= r_snpc;
            commit_valid <= 1'b1;
            err          <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ysyx_25020047_wb_commit_ctrl.sv
// Directed bench for ysyx_25020047_wb_commit_ctrl: ALU/link/branch/x0/unknown commits,
// lbu/lw load paths, memory timeout and reset during an outstanding load.
module tb_ysyx_25020047_wb_commit_ctrl;

   localparam logic [63:0] T_ADDI = 64'h1 << 0;
   localparam logic [63:0] T_JAL  = 64'h1 << 10;
   localparam logic [63:0] T_BNE  = 64'h1 << 15;
   localparam logic [63:0] T_LW   = 64'h1 << 5;
   localparam logic [63:0] T_LBU  = 64'h1 << 6;
   localparam logic [63:0] T_UNK  = 64'h1 << 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] in_inst_type = '0;
   logic [4:0]  in_rd = '0;
   logic [31:0] in_result = '0;
   logic [31:0] in_snpc = '0;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b0;
   logic [31:0] mem_req_addr;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        gpr_wen;
   logic [4:0]  gpr_waddr;
   logic [31:0] gpr_wdata;
   logic        pc_wen;
   logic [31:0] pc_dnpc;
   logic        commit_valid;
   logic        err;

   int n_checks = 0;
   int n_errors = 0;

   ysyx_25020047_wb_commit_ctrl #(.MEM_TIMEOUT(255)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_inst_type(in_inst_type),
      .in_rd(in_rd), .in_result(in_result), .in_snpc(in_snpc),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
      .pc_wen(pc_wen), .pc_dnpc(pc_dnpc), .commit_valid(commit_valid), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents one instruction for exactly one accept edge, then scrambles the inputs.
   task automatic issue(input logic [63:0] t, input logic [4:0] rd,
                        input logic [31:0] res, input logic [31:0] snpc);
      in_inst_type = t;
      in_rd        = rd;
      in_result    = res;
      in_snpc      = snpc;
      in_valid     = 1'b1;
      step();
      in_valid     = 1'b0;
      in_inst_type = T_JAL;
      in_rd        = 5'd31;
      in_result    = 32'hDEAD_BEEF;
      in_snpc      = 32'h0BAD_0000;
   endtask

   task automatic commit_chk(input string tag, input logic wen, input logic [4:0] waddr,
                             input logic [31:0] wdata, input logic [31:0] dnpc, input logic e);
      chk({tag, "_commit"}, commit_valid, 1'b1);
      chk({tag, "_pc_wen"}, pc_wen, 1'b1);
      chk({tag, "_gpr_wen"}, gpr_wen, wen);
      if (wen) begin
         chk({tag, "_waddr"}, gpr_waddr, waddr);
         chk({tag, "_wdata"}, gpr_wdata, wdata);
      end
      chk({tag, "_dnpc"}, pc_dnpc, dnpc);
      chk({tag, "_err"}, err, e);
      step();
      chk({tag, "_commit_drop"}, commit_valid, 1'b0);
      chk({tag, "_wen_drop"}, gpr_wen, 1'b0);
      chk({tag, "_ready_back"}, in_ready, 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      #1;
      chk("rst_ready", in_ready, 1'b1);
      chk("rst_commit", commit_valid, 1'b0);
      chk("rst_gpr_wen", gpr_wen, 1'b0);
      chk("rst_pc_wen", pc_wen, 1'b0);
      chk("rst_req", mem_req_valid, 1'b0);
      chk("rst_err", err, 1'b0);
      step();
      @(negedge clk) rst_n = 1'b1;
      step();

      issue(T_ADDI, 5'd5, 32'h10, 32'h8000_0004);
      chk("addi_busy", in_ready, 1'b0);
      commit_chk("addi", 1'b1, 5'd5, 32'h10, 32'h8000_0004, 1'b0);

      issue(T_JAL, 5'd1, 32'h8000_0100, 32'h8000_0008);
      commit_chk("jal", 1'b1, 5'd1, 32'h8000_0008, 32'h8000_0100, 1'b0);

      issue(T_BNE, 5'd7, 32'h8000_0040, 32'h8000_000C);
      commit_chk("bne", 1'b0, 5'd7, 32'h0, 32'h8000_0040, 1'b0);

      issue(T_ADDI, 5'd0, 32'h55, 32'h8000_0010);
      commit_chk("addi_x0", 1'b0, 5'd0, 32'h0, 32'h8000_0010, 1'b0);

      issue(T_UNK, 5'd3, 32'h8000_0700, 32'h8000_0014);
      commit_chk("unlisted", 1'b0, 5'd3, 32'h0, 32'h8000_0014, 1'b1);

      issue(T_ADDI | T_JAL, 5'd3, 32'h8000_0700, 32'h8000_0018);
      commit_chk("multihot", 1'b0, 5'd3, 32'h0, 32'h8000_0018, 1'b1);

      issue(64'h0, 5'd3, 32'h8000_0700, 32'h8000_001C);
      commit_chk("zero_type", 1'b0, 5'd3, 32'h0, 32'h8000_001C, 1'b1);

      // lbu: request accepted 2 cycles late, response 3 cycles after handshake
      issue(T_LBU, 5'd12, 32'h8000_1003, 32'h8000_0020);
      chk("lbu_req", mem_req_valid, 1'b1);
      chk("lbu_addr", mem_req_addr, 32'h8000_1000);
      chk("lbu_busy", in_ready, 1'b0);
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h1111_1111;
      step();
      mem_rvalid = 1'b0;
      chk("lbu_req_hold", mem_req_valid, 1'b1);
      chk("lbu_addr_hold", mem_req_addr, 32'h8000_1000);
      chk("lbu_early_rvalid", commit_valid, 1'b0);
      step();
      chk("lbu_req_hold2", mem_req_valid, 1'b1);
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      chk("lbu_req_drop", mem_req_valid, 1'b0);
      chk("lbu_wait0", commit_valid, 1'b0);
      step();
      chk("lbu_wait1", commit_valid, 1'b0);
      step();
      chk("lbu_wait2", commit_valid, 1'b0);
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hAABB_CCDD;
      step();
      mem_rvalid = 1'b0;
      commit_chk("lbu", 1'b1, 5'd12, 32'h0000_00AA, 32'h8000_0020, 1'b0);

      // lw with zero wait states
      issue(T_LW, 5'd20, 32'h8000_2006, 32'h8000_0024);
      chk("lw_addr", mem_req_addr, 32'h8000_2004);
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h1234_5678;
      step();
      mem_rvalid = 1'b0;
      commit_chk("lw", 1'b1, 5'd20, 32'h1234_5678, 32'h8000_0024, 1'b0);

      // lw whose response never arrives
      issue(T_LW, 5'd21, 32'h8000_3000, 32'h8000_0028);
      mem_req_ready = 1'b1;
      cnt = 0;
      while (!commit_valid && cnt < 400) begin
         step();
         mem_req_ready = 1'b0;
         cnt++;
      end
      chk("to_latency", cnt, 255);
      commit_chk("timeout", 1'b0, 5'd21, 32'h0, 32'h8000_0028, 1'b1);
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hFFFF_FFFF;
      step();
      step();
      mem_rvalid = 1'b0;
      chk("late_rvalid_commit", commit_valid, 1'b0);
      chk("late_rvalid_wen", gpr_wen, 1'b0);
      chk("late_rvalid_ready", in_ready, 1'b1);

      // reset while waiting for a load response
      issue(T_LW, 5'd9, 32'h8000_0200, 32'h8000_002C);
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      chk("rstmid_in_wait", in_ready, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("rstmid_ready", in_ready, 1'b1);
      chk("rstmid_req", mem_req_valid, 1'b0);
      @(negedge clk) rst_n = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h0000_0077;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rstmid_commit", commit_valid, 1'b0);
         chk("rstmid_wen", gpr_wen, 1'b0);
         chk("rstmid_idle", in_ready, 1'b1);
      end
      mem_rvalid = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
